// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 RS232 receive controller.
//
// The serial line is passed through a 2-FF synchronizer. A bit-period counter
// runs 0..limit and wraps on its terminal count (tick). The frame FSM uses a
// half-bit period to align to the middle of the start bit, then full-bit
// periods to sample each data bit and the stop bit at mid-bit.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   rx_i         asynchronous serial input, idles high
//   baud_div_i   bit period minus 1 in clk cycles (>= 3), latched per frame
//   data_o       last correctly framed byte
//   rx_done_o    one-cycle strobe, data_o updated
//   frame_err_o  one-cycle strobe, stop bit read as 0
//   busy_o       high whenever the FSM is not idle
module uart_rx_ctrl #(
  parameter int Width    = 14,
  parameter int DataBits = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rx_i,
  input  logic [Width-1:0]    baud_div_i,
  output logic [DataBits-1:0] data_o,
  output logic                rx_done_o,
  output logic                frame_err_o,
  output logic                busy_o
);

  localparam int IdxW = $clog2(DataBits + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_sync1, r_sync2;
  logic                w_rxs;
  logic [Width-1:0]    r_cnt, r_div_q, w_limit;
  logic                w_tick;
  logic [IdxW-1:0]     r_bit_idx;
  logic [DataBits-1:0] r_shift, r_data;
  logic                r_done, r_ferr;

  logic                w_launch, w_shift_en, w_done_set, w_ferr_set;

  assign w_rxs = r_sync2;

  // Half period in START puts every later sample near mid-bit.
  assign w_limit = (r_state == START) ? (r_div_q >> 1) : r_div_q;
  assign w_tick  = (r_cnt == w_limit);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_shift_en  = 1'b0;
    w_done_set  = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = START;
          w_launch    = 1'b1;
        end
      end
      START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (w_tick) w_state_nxt = w_rxs ? IDLE : DATA;
      end
      DATA: begin
        if (w_tick) begin
          w_shift_en = 1'b1;
          if (r_bit_idx == IdxW'(DataBits - 1)) w_state_nxt = STOP;
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch the next start edge.
        if (w_tick) begin
          w_state_nxt = IDLE;
          if (w_rxs) w_done_set = 1'b1;
          else       w_ferr_set = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_cnt     <= '0;
      r_div_q   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_done  <= w_done_set;
      r_ferr  <= w_ferr_set;

      if (r_state == IDLE || w_tick) r_cnt <= '0;
      else                           r_cnt <= r_cnt + Width'(1);

      if (w_launch) begin
        r_div_q   <= baud_div_i;
        r_bit_idx <= '0;
      end

      // Right shift: the first (LSB) bit ends up in bit 0 after DataBits samples.
      if (w_shift_en) begin
        r_shift   <= {w_rxs, r_shift[DataBits-1:1]};
        r_bit_idx <= r_bit_idx + IdxW'(1);
      end

      if (w_done_set) r_data <= r_shift;
    end
  end

  assign data_o      = r_data;
  assign rx_done_o   = r_done;
  assign frame_err_o = r_ferr;
  assign busy_o      = (r_state != IDLE);

endmodule
